// File: rtl/pong_game.sv
// Two-player pong: frame-rate game state (paddles, ball, scores, serve/point FSM)
// plus a registered pixel colour path driven by the external video timing.
module pong_game #(
  parameter int H_ACTIVE     = 480,
  parameter int V_ACTIVE     = 272,
  parameter int POS_W        = 9,
  parameter int PADDLE_W     = 6,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPD   = 4,
  parameter int BALL_SZ      = 6,
  parameter int MAX_SPD      = 4,
  parameter int HITS_PER_LVL = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int MAX_SCORE    = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_up,
  input  logic [1:0]       i_down,
  input  logic             i_data_enable,
  input  logic [POS_W-1:0] i_col,
  input  logic [POS_W-1:0] i_row,
  output logic [7:0]       o_red,
  output logic [7:0]       o_green,
  output logic [7:0]       o_blue,
  output logic [3:0]       o_score1,
  output logic [3:0]       o_score2,
  output logic             o_game_over
);

  localparam int SW      = POS_W + 1;
  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HIT_W   = $clog2(HITS_PER_LVL + 1);

  typedef logic signed [SW-1:0] spos_t;

  localparam spos_t ZERO       = spos_t'(0);
  localparam spos_t ONE        = spos_t'(1);
  localparam spos_t BALL_X0    = spos_t'((H_ACTIVE - BALL_SZ) / 2);
  localparam spos_t BALL_Y0    = spos_t'((V_ACTIVE - BALL_SZ) / 2);
  localparam spos_t PAD_Y0     = spos_t'((V_ACTIVE - PADDLE_H) / 2);
  localparam spos_t PAD_Y_MAX  = spos_t'(V_ACTIVE - PADDLE_H);
  localparam spos_t BALL_X_MAX = spos_t'(H_ACTIVE - BALL_SZ);
  localparam spos_t BALL_Y_MAX = spos_t'(V_ACTIVE - BALL_SZ);
  localparam spos_t HIT_X_L    = spos_t'(PADDLE_W);
  localparam spos_t HIT_X_R    = spos_t'(H_ACTIVE - PADDLE_W - BALL_SZ);
  localparam spos_t PAD_X_R    = spos_t'(H_ACTIVE - PADDLE_W);
  localparam spos_t PAD_STEP   = spos_t'(PADDLE_SPD);
  localparam spos_t PAD_H      = spos_t'(PADDLE_H);
  localparam spos_t BALL_S     = spos_t'(BALL_SZ);
  localparam spos_t SPD_MAX    = spos_t'(MAX_SPD);
  localparam logic [3:0] MAX_S = 4'(MAX_SCORE);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

  function automatic spos_t move_paddle(spos_t y, logic up, logic dn);
    spos_t n;
    n = y;
    if (dn && !up)      n = y + PAD_STEP;
    else if (up && !dn) n = y - PAD_STEP;
    if (n < ZERO)           n = ZERO;
    else if (n > PAD_Y_MAX) n = PAD_Y_MAX;
    return n;
  endfunction

  function automatic spos_t bump_speed(spos_t s);
    return (s >= SPD_MAX) ? SPD_MAX : s + ONE;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  spos_t            bx_q, bx_d, by_q, by_d, vx_q, vx_d, vy_q, vy_d;
  spos_t            p1_q, p1_d, p2_q, p2_d, speed_q, speed_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             dir_q, dir_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic             frame_tick, ov1, ov2, lvl_up;
  logic [HIT_W-1:0] hits_inc;
  spos_t            nx, ny, spd_hit, col_s, row_s;

  assign frame_tick = i_data_enable && (i_col == POS_W'(H_ACTIVE - 1))
                      && (i_row == POS_W'(V_ACTIVE - 1));

  // Ball/paddle overlap is judged on pre-update positions
  assign ov1 = (by_q + BALL_S > p1_q) && (by_q < p1_q + PAD_H);
  assign ov2 = (by_q + BALL_S > p2_q) && (by_q < p2_q + PAD_H);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bx_d     = bx_q;
    by_d     = by_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    speed_d  = speed_q;
    hits_d   = hits_q;
    dir_d    = dir_q;
    score1_d = score1_q;
    score2_d = score2_q;
    nx       = bx_q + vx_q;
    ny       = by_q + vy_q;
    hits_inc = hits_q + HIT_W'(1);
    lvl_up   = (hits_inc == HIT_W'(HITS_PER_LVL));
    spd_hit  = lvl_up ? bump_speed(speed_q) : speed_q;
    if (frame_tick) begin
      p1_d = move_paddle(p1_q, i_up[0], i_down[0]);
      p2_d = move_paddle(p2_q, i_up[1], i_down[1]);
      case (state_q)
        SERVE: begin
          bx_d = BALL_X0;
          by_d = BALL_Y0;
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            cnt_d   = '0;
            vx_d    = dir_q ? speed_q : -speed_q;
            vy_d    = ONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PLAY: begin
          if (ny <= ZERO) begin
            by_d = ZERO;
            vy_d = ONE;
          end else if (ny >= BALL_Y_MAX) begin
            by_d = BALL_Y_MAX;
            vy_d = -ONE;
          end else begin
            by_d = ny;
          end
          // Paddle returns take precedence over misses
          if (nx <= HIT_X_L && ov1) begin
            bx_d    = HIT_X_L;
            vx_d    = spd_hit;
            speed_d = spd_hit;
            hits_d  = lvl_up ? '0 : hits_inc;
          end else if (nx >= HIT_X_R && ov2) begin
            bx_d    = HIT_X_R;
            vx_d    = -spd_hit;
            speed_d = spd_hit;
            hits_d  = lvl_up ? '0 : hits_inc;
          end else if (nx < ZERO) begin
            bx_d     = nx;
            score2_d = score2_q + 4'd1;
            dir_d    = 1'b0;
            state_d  = POINT;
            cnt_d    = '0;
            speed_d  = ONE;
            hits_d   = '0;
          end else if (nx > BALL_X_MAX) begin
            bx_d     = nx;
            score1_d = score1_q + 4'd1;
            dir_d    = 1'b1;
            state_d  = POINT;
            cnt_d    = '0;
            speed_d  = ONE;
            hits_d   = '0;
          end else begin
            bx_d = nx;
          end
        end
        POINT: begin
          if (cnt_q == CNT_W'(POINT_FRAMES - 1)) begin
            cnt_d = '0;
            if (score1_q == MAX_S || score2_q == MAX_S) begin
              state_d = OVER;
            end else begin
              state_d = SERVE;
              bx_d    = BALL_X0;
              by_d    = BALL_Y0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OVER: begin
          if (|i_up) begin
            score1_d = '0;
            score2_d = '0;
            state_d  = SERVE;
            cnt_d    = '0;
            bx_d     = BALL_X0;
            by_d     = BALL_Y0;
          end
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SERVE;
      cnt_q    <= '0;
      bx_q     <= BALL_X0;
      by_q     <= BALL_Y0;
      vx_q     <= ONE;
      vy_q     <= ONE;
      p1_q     <= PAD_Y0;
      p2_q     <= PAD_Y0;
      speed_q  <= ONE;
      hits_q   <= '0;
      dir_q    <= 1'b1;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      speed_q  <= speed_d;
      hits_q   <= hits_d;
      dir_q    <= dir_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end
  end

  // Pixel path: one register stage from col/row/enable to colour
  assign col_s = spos_t'({1'b0, i_col});
  assign row_s = spos_t'({1'b0, i_row});

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (i_data_enable) begin
      if (col_s < HIT_X_L && row_s >= p1_q && row_s < p1_q + PAD_H) begin
        red_d   = 8'hFF;
        green_d = 8'hFF;
      end else if (col_s >= PAD_X_R && row_s >= p2_q && row_s < p2_q + PAD_H) begin
        red_d   = 8'hFF;
        green_d = 8'hFF;
        blue_d  = 8'hFF;
      end else if ((state_q == SERVE || state_q == PLAY)
                   && col_s >= bx_q && col_s < bx_q + BALL_S
                   && row_s >= by_q && row_s < by_q + BALL_S) begin
        green_d = 8'hFF;
        blue_d  = 8'hFF;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_red       = red_q;
  assign o_green     = green_q;
  assign o_blue      = blue_q;
  assign o_score1    = score1_q;
  assign o_score2    = score2_q;
  assign o_game_over = (state_q == OVER);

endmodule
